// File: rtl/mem_arb_pkg.sv
// mem_arb shared types: FSM state encoding, requester id, requester count.
// Imported by mem_arb and mem_arb_rr.
package mem_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef logic [0:0] req_id_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational two-way round-robin picker.
// On a tie the requester not granted last time wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            last_grant,
  output logic               grant_valid,
  output req_id_t            grant_id
);

  // Pick the sole requester, or alternate on a tie.
  always_comb begin
    grant_valid = |req;
    grant_id    = req_id_t'(req[1]);
    if (req == 2'b11) begin
      grant_id = ~last_grant;
    end
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb: serialises fetch (0) and load/store (1) onto one memory port.
// Optional macro MEM_ARB_PERF_EN adds grant/conflict counters.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i,
  input  logic [NUM_REQ-1:0]            we_i,
  input  logic [NUM_REQ-1:0][3:0]       be_i,
  input  logic [NUM_REQ-1:0][31:0]      wdata_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [31:0]                   rdata_o,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [3:0]                    mem_be,
  output logic [31:0]                   mem_wdata,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0]                   perf_grant0_o,
  output logic [31:0]                   perf_grant1_o,
  output logic [31:0]                   perf_conflict_o,
`endif
  input  logic [31:0]                   mem_rdata
);

  state_e            state_q, state_d;
  req_id_t           last_q, last_d;
  req_id_t           id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              gnt_valid;
  req_id_t           gnt_id;
  logic              issue;
  logic              resp;

  mem_arb_rr u_rr (
    .req         (req_i),
    .last_grant  (last_q),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  // Transaction sequencing: grant, issue, wait out latency, respond.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_ISSUE;
          id_d    = gnt_id;
          last_d  = gnt_id;
          addr_d  = addr_i[gnt_id];
          we_d    = we_i[gnt_id];
          be_d    = be_i[gnt_id];
          wdata_d = wdata_i[gnt_id];
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = 2'(MEM_LATENCY - 1);
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_RESP;
          rdata_d = we_q ? 32'd0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latch registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      last_q  <= req_id_t'(1'b1);
      id_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory port is quiet outside ISSUE; ack follows the latched id.
  always_comb begin
    issue     = (state_q == ST_ISSUE);
    resp      = (state_q == ST_RESP);
    mem_en    = issue;
    mem_we    = issue & we_q;
    mem_addr  = issue ? addr_q : '0;
    mem_be    = issue ? be_q : '0;
    mem_wdata = issue ? wdata_q : '0;
    ack_o[0]  = resp & ~id_q[0];
    ack_o[1]  = resp & id_q[0];
    rdata_o   = rdata_q;
  end

`ifdef MEM_ARB_PERF_EN
  logic [31:0] g0_q, g0_d;
  logic [31:0] g1_q, g1_d;
  logic [31:0] cf_q, cf_d;
  logic        grant_now;
  logic [1:0]  served;
  logic [1:0]  waiting;

  // Count grants, and edges on which some request is left waiting.
  always_comb begin
    grant_now = (state_q == ST_IDLE) & gnt_valid;
    served    = 2'b00;
    if (grant_now) begin
      served = gnt_id[0] ? 2'b10 : 2'b01;
    end else if (state_q != ST_IDLE) begin
      served = id_q[0] ? 2'b10 : 2'b01;
    end
    waiting = req_i & ~served;
    g0_d    = g0_q + {31'd0, grant_now & ~gnt_id[0]};
    g1_d    = g1_q + {31'd0, grant_now & gnt_id[0]};
    cf_d    = cf_q + {31'd0, |waiting};
  end

  // Performance counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g0_q <= '0;
      g1_q <= '0;
      cf_q <= '0;
    end else begin
      g0_q <= g0_d;
      g1_q <= g1_d;
      cf_q <= cf_d;
    end
  end

  assign perf_grant0_o   = g0_q;
  assign perf_grant1_o   = g1_q;
  assign perf_conflict_o = cf_q;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: one instance at latency 1 with a memory
// model, one at latency 3 with hand-driven read data.
module tb_mem_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  logic [1:0]       req_a, ack_a, we_a;
  logic [1:0][31:0] addr_a, wdata_a;
  logic [1:0][3:0]  be_a;
  logic [31:0]      rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic             mem_en_a, mem_we_a;
  logic [3:0]       mem_be_a;

  logic [1:0]       req_b, ack_b, we_b;
  logic [1:0][31:0] addr_b, wdata_b;
  logic [1:0][3:0]  be_b;
  logic [31:0]      rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic             mem_en_b, mem_we_b;
  logic [3:0]       mem_be_b;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] pg0_a, pg1_a, pcf_a, pg0_b, pg1_b, pcf_b;
`endif

  mem_arb #(.MEM_LATENCY(1), .ADDR_W(32)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_a),
    .addr_i    (addr_a),
    .we_i      (we_a),
    .be_i      (be_a),
    .wdata_i   (wdata_a),
    .ack_o     (ack_a),
    .rdata_o   (rdata_a),
    .mem_en    (mem_en_a),
    .mem_we    (mem_we_a),
    .mem_addr  (mem_addr_a),
    .mem_be    (mem_be_a),
    .mem_wdata (mem_wdata_a),
`ifdef MEM_ARB_PERF_EN
    .perf_grant0_o   (pg0_a),
    .perf_grant1_o   (pg1_a),
    .perf_conflict_o (pcf_a),
`endif
    .mem_rdata (mem_rdata_a)
  );

  mem_arb #(.MEM_LATENCY(3), .ADDR_W(32)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_b),
    .addr_i    (addr_b),
    .we_i      (we_b),
    .be_i      (be_b),
    .wdata_i   (wdata_b),
    .ack_o     (ack_b),
    .rdata_o   (rdata_b),
    .mem_en    (mem_en_b),
    .mem_we    (mem_we_b),
    .mem_addr  (mem_addr_b),
    .mem_be    (mem_be_b),
    .mem_wdata (mem_wdata_b),
`ifdef MEM_ARB_PERF_EN
    .perf_grant0_o   (pg0_b),
    .perf_grant1_o   (pg1_b),
    .perf_conflict_o (pcf_b),
`endif
    .mem_rdata (mem_rdata_b)
  );

  // Synchronous single-cycle memory for dut_a.
  logic [31:0] mem [256];

  always @(posedge clk) begin
    if (mem_en_a) begin
      if (mem_we_a) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_a[b]) mem[mem_addr_a[9:2]][8*b +: 8] <= mem_wdata_a[8*b +: 8];
        end
      end else begin
        mem_rdata_a <= mem[mem_addr_a[9:2]];
      end
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_ack;
  logic [31:0] exp_rd;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] g0_s, g1_s, cf_s;
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h40] = 32'hDEADBEEF;
    mem_rdata_a = 32'h0;
    req_a = '0; we_a = '0; be_a = '0; addr_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; be_b = '0; addr_b = '0; wdata_b = '0;
    mem_rdata_b = 32'h0;

    // Reset values
    tick();
    tick();
    chk("rst_ack", {30'd0, ack_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_en", {31'd0, mem_en_a}, 32'd0);
    chk("rst_we", {31'd0, mem_we_a}, 32'd0);
    chk("rst_addr", mem_addr_a, 32'd0);
    chk("rst_be", {28'd0, mem_be_a}, 32'd0);
    chk("rst_wdata", mem_wdata_a, 32'd0);
    reset = 1'b0;

    // Single read by requester 0
    req_a = 2'b01; addr_a[0] = 32'h100; be_a[0] = 4'hF;
    tick();
    chk("rd_en", {31'd0, mem_en_a}, 32'd1);
    chk("rd_addr", mem_addr_a, 32'h100);
    chk("rd_we", {31'd0, mem_we_a}, 32'd0);
    tick();
    chk("rd_en_off", {31'd0, mem_en_a}, 32'd0);
    chk("rd_ack_early", {30'd0, ack_a}, 32'd0);
    tick();
    chk("rd_ack", {30'd0, ack_a}, 32'd1);
    chk("rd_data", rdata_a, 32'hDEADBEEF);
    req_a = 2'b00;
    tick();
    chk("rd_ack_end", {30'd0, ack_a}, 32'd0);

    // Write by requester 1
    req_a = 2'b10; we_a[1] = 1'b1; be_a[1] = 4'hF;
    addr_a[1] = 32'h200; wdata_a[1] = 32'h600D600D;
    tick();
    chk("wr_en", {31'd0, mem_en_a}, 32'd1);
    chk("wr_we", {31'd0, mem_we_a}, 32'd1);
    chk("wr_addr", mem_addr_a, 32'h200);
    chk("wr_be", {28'd0, mem_be_a}, 32'hF);
    chk("wr_wdata", mem_wdata_a, 32'h600D600D);
    tick();
    chk("wr_we_off", {31'd0, mem_we_a}, 32'd0);
    tick();
    chk("wr_ack", {30'd0, ack_a}, 32'd2);
    chk("wr_rdata", rdata_a, 32'd0);
    req_a = 2'b00; we_a[1] = 1'b0;
    tick();

    // Read back the written word
    req_a = 2'b01; addr_a[0] = 32'h200;
    tick();
    tick();
    tick();
    chk("rb_ack", {30'd0, ack_a}, 32'd1);
    chk("rb_data", rdata_a, 32'h600D600D);
    req_a = 2'b00;
    tick();

    // Reset in WAIT: nothing completes, last grant returns to 1
    req_a = 2'b01; addr_a[0] = 32'h100;
    tick();
    tick();
    req_a = 2'b00;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_en", {31'd0, mem_en_a}, 32'd0);
    chk("mid_rst_ack", {30'd0, ack_a}, 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("mid_rst_noack", {30'd0, ack_a}, 32'd0);
    end

    // Tie held for 4 transactions: grants 0,1,0,1 every 4 cycles
    addr_a[0] = 32'h100;
    addr_a[1] = 32'h200;
    req_a = 2'b11;
`ifdef MEM_ARB_PERF_EN
    g0_s = pg0_a; g1_s = pg1_a; cf_s = pcf_a;
`endif
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_ack = 2'b00;
      exp_rd  = 32'h0;
      if (k == 2 || k == 10) begin
        exp_ack = 2'b01; exp_rd = 32'hDEADBEEF;
      end
      if (k == 6 || k == 14) begin
        exp_ack = 2'b10; exp_rd = 32'h600D600D;
      end
      chk("tie_ack", {30'd0, ack_a}, {30'd0, exp_ack});
      if (exp_ack != 2'b00) chk("tie_data", rdata_a, exp_rd);
    end
`ifdef MEM_ARB_PERF_EN
    chk("perf_g0", pg0_a - g0_s, 32'd2);
    chk("perf_g1", pg1_a - g1_s, 32'd2);
    chk("perf_cf", pcf_a - cf_s, 32'd16);
`endif
    req_a = 2'b00;
    tick();

    // Latency 3: ack five edges after sampling, data from capture edge
    req_b = 2'b01; addr_b[0] = 32'h40;
    mem_rdata_b = 32'h11111111;
    tick();
    chk("l3_en", {31'd0, mem_en_b}, 32'd1);
    chk("l3_addr", mem_addr_b, 32'h40);
    tick();
    chk("l3_ack_e1", {30'd0, ack_b}, 32'd0);
    tick();
    chk("l3_ack_e2", {30'd0, ack_b}, 32'd0);
    tick();
    chk("l3_ack_e3", {30'd0, ack_b}, 32'd0);
    mem_rdata_b = 32'hCAFEF00D;
    tick();
    chk("l3_ack", {30'd0, ack_b}, 32'd1);
    chk("l3_data", rdata_b, 32'hCAFEF00D);
    mem_rdata_b = 32'h22222222;
    req_b = 2'b00;
    tick();
    chk("l3_ack_end", {30'd0, ack_b}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
# mem_arb

Two-requester arbiter sharing one main-memory port between the instruction-fetch path (requester 0) and the load/store path (requester 1) of the psp core. It serialises transactions, picks between simultaneous requests with round-robin priority, drives a single synchronous memory port, and returns read data with a one-cycle ack pulse. It sits between the core/cache miss paths and the `memory` instance, clocked by `coreclk`.

## Interface
- `MEM_LATENCY`, default 1: memory edges from address/enable sample to valid `mem_rdata`; legal range 1..4.
- `ADDR_W`, default 32: address width.
- `clk` in 1: core clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_i[1:0]` in 2: per-requester request; held high until ack.
- `addr_i[1:0]` in 2×ADDR_W: per-requester byte address, stable while `req_i` high.
- `we_i[1:0]` in 2: per-requester write enable.
- `be_i[1:0]` in 2×4: per-requester byte enables.
- `wdata_i[1:0]` in 2×32: per-requester write data.
- `ack_o[1:0]` out 2: one-cycle completion pulse per requester.
- `rdata_o` out 32: read data, valid while the matching `ack_o` bit is high.
- `mem_en` out 1: memory port enable.
- `mem_we` out 1: memory write enable.
- `mem_addr` out ADDR_W: memory address.
- `mem_be` out 4: memory byte enables.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: on an edge with any `req_i` set, choose a winner, latch its addr/we/be/wdata and id, go to ISSUE.
- Pick: one request wins outright; if both, the requester not granted last wins. `last_grant` resets to 1, so requester 0 wins the first tie.
- ISSUE, one cycle: `mem_en`=1, `mem_we`=latched we, other mem outputs from the latch. Then go to WAIT with a counter loaded to MEM_LATENCY-1. If MEM_LATENCY=1, go straight to the WAIT capture edge.
- WAIT: the counter decrements. When it reaches 0, capture `mem_rdata` into `rdata_o` (reads), or 0 (writes), and go to RESP.
- RESP, one cycle: `ack_o[id]`=1. Then return to IDLE without sampling `req_i` on that edge.
- Requester rule: drop `req_i` on the edge that sees `ack_o`. A `req_i` still high at the next IDLE edge is a new transaction.
- Changing addr/we/be/wdata while `req_i` is high before ack is illegal; the latched values are used.
- `mem_*` outputs are 0 whenever not in ISSUE.
- Addresses pass through unmodified; address decode stays outside the block.

## Timing
- Reset values: `ack_o`=0, `rdata_o`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_be`=0, `mem_wdata`=0, state IDLE, `last_grant`=1.
- Req sampled at edge N: `mem_en` high in cycle N→N+1; `ack_o` high in cycle N+1+MEM_LATENCY → N+2+MEM_LATENCY.
- Latency is 3 edges for MEM_LATENCY=1.
- Back-to-back throughput: one transaction per 3+MEM_LATENCY cycles.
- Loser of a tie waits exactly one transaction.
- Reset asserted mid-transaction: all outputs go to 0 immediately (asynchronous); the in-flight transaction is dropped with no ack.
- Reset deasserting while `req_i` is high: that request is sampled at the first edge after release.
- Simultaneous new request from the current winner and a pending loser: the loser wins (round-robin).

## Configuration
- `MEM_ARB_PERF_EN` defined: adds outputs `perf_grant0_o`, `perf_grant1_o` and `perf_conflict_o`, each 32 bits.
  - Grant counters increment on each IDLE→ISSUE grant for that requester.
  - The conflict counter increments on every edge where a `req_i` bit is high but not granted, including while busy.
  - All three wrap modulo 2^32 and reset to 0.
- `MEM_ARB_PERF_EN` undefined: the counters and their ports do not exist; arbitration behaviour is identical.

## Structure
- Shared package `mem_arb_pkg`: state enum (IDLE/ISSUE/WAIT/RESP), `req_id_t` (1-bit requester id), `NUM_REQ`=2.
- Sub-module `mem_arb_rr`: combinational round-robin picker. Inputs are `req`, `last_grant`; outputs are `grant_valid`, `grant_id`.

## Test plan
- Single read, MEM_LATENCY=1: req0 high at edge 0, addr 0x100, memory word 0xDEADBEEF → `mem_en` in cycle 0→1 with `mem_addr`=0x100; `ack_o`=2'b01 with `rdata_o`=0xDEADBEEF in cycle 2→3.
- Write: req1 writes wdata 0x600D600D, be 4'b1111, addr 0x200 → `mem_we`=1 for exactly one cycle; `ack_o`=2'b10 with `rdata_o`=0; a later read of 0x200 returns 0x600D600D.
- Tie and round-robin: both req high continuously for 4 transactions → grant order 0,1,0,1; the loser's ack arrives 3+MEM_LATENCY cycles after the winner's.
- Latency sweep: MEM_LATENCY=3 read → ack exactly 5 edges after the sampling edge; `rdata_o` equals `mem_rdata` presented at the capture edge.
- Reset mid-op: assert reset during WAIT → `mem_*` and `ack_o` are 0 immediately, no ack after release, `last_grant`=1; the next tie goes to requester 0.
- `MEM_ARB_PERF_EN`: 3 contested transactions → `perf_grant0_o`+`perf_grant1_o`=3 and `perf_conflict_o` matches the counted waiting edges.
